// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq -- sequential double-dabble binary-to-BCD converter.
//
// Converts a BIN_W-bit value into DIGITS packed BCD digits, one bit per
// clock, behind a start/busy/done handshake. Optional two's-complement
// input (magnitude converted, sign reported separately), saturation to
// all nines on overflow, and a leading-zero mask for display blanking.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   start      conversion request, honoured only when idle
//   bin_in     value to convert, captured on the accepting edge
//   busy       high while a conversion is in flight (state != IDLE)
//   done       one-cycle pulse when a new result is presented
//   bcd_out    digit i at [4i+3:4i], digit 0 = units
//   neg        sign of the converted value (never set for zero)
//   overflow   magnitude exceeded 10^DIGITS-1; bcd_out holds all nines
//   lead_zero  bit i set if digit i and every higher digit are zero
module bin2bcd_seq #(
  parameter int BIN_W  = 12,
  parameter int DIGITS = 4,
  parameter int SIGNED = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  neg,
  output logic                  overflow,
  output logic [DIGITS-1:0]     lead_zero
);

  localparam int SCR_W = 4 * DIGITS;
  // Counter must also hold BIN_W after the final increment.
  localparam int CNT_W = $clog2(BIN_W + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t             state;
  state_t             state_nxt;
  logic [BIN_W-1:0]   mag;
  logic [SCR_W-1:0]   scratch;
  logic [CNT_W-1:0]   cnt;
  logic               sign;
  logic               ovf;
  logic               last_step;
  logic [SCR_W-1:0]   adj;
  logic [SCR_W:0]     shifted;
  logic [SCR_W-1:0]   result;

  // Two's-complement magnitude; the most negative value maps to
  // 2^(BIN_W-1), which still fits in BIN_W unsigned bits.
  function automatic logic [BIN_W-1:0] magnitude(input logic [BIN_W-1:0] v);
    if ((SIGNED != 0) && v[BIN_W-1])
      return (~v) + BIN_W'(1);
    return v;
  endfunction

  // Double-dabble correction: every digit >= 5 gets +3, independently.
  function automatic logic [SCR_W-1:0] dabble_adjust(input logic [SCR_W-1:0] s);
    logic [SCR_W-1:0] r;
    r = s;
    for (int d = 0; d < DIGITS; d++) begin
      if (s[4*d +: 4] >= 4'd5)
        r[4*d +: 4] = s[4*d +: 4] + 4'd3;
    end
    return r;
  endfunction

  function automatic logic [SCR_W-1:0] saturate(input logic [SCR_W-1:0] s,
                                                input logic            o);
    return o ? {DIGITS{4'h9}} : s;
  endfunction

  // Units digit is never blanked, so bit 0 stays 0.
  function automatic logic [DIGITS-1:0] lead_zeros(input logic [SCR_W-1:0] b);
    logic [DIGITS-1:0] r;
    logic              z;
    r = '0;
    z = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      z    = z & (b[4*i +: 4] == 4'd0);
      r[i] = z;
    end
    return r;
  endfunction

  assign last_step = (cnt == CNT_W'(BIN_W - 1));
  assign adj       = dabble_adjust(scratch);
  // Top bit is the bit leaving the scratch MSB; it flags overflow.
  assign shifted   = {adj, mag[BIN_W-1]};
  assign result    = saturate(scratch, ovf);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = SHIFT;
      SHIFT:   if (last_step) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy = (state != IDLE);
  end

  // Datapath: capture, shift, publish
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mag       <= '0;
      scratch   <= '0;
      cnt       <= '0;
      sign      <= 1'b0;
      ovf       <= 1'b0;
      done      <= 1'b0;
      bcd_out   <= '0;
      neg       <= 1'b0;
      overflow  <= 1'b0;
      lead_zero <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            mag     <= magnitude(bin_in);
            sign    <= (SIGNED != 0) && bin_in[BIN_W-1];
            scratch <= '0;
            cnt     <= '0;
            ovf     <= 1'b0;
          end
        end
        SHIFT: begin
          scratch <= shifted[SCR_W-1:0];
          mag     <= {mag[BIN_W-2:0], 1'b0};
          cnt     <= cnt + CNT_W'(1);
          ovf     <= ovf | shifted[SCR_W];
        end
        DONE: begin
          done      <= 1'b1;
          bcd_out   <= result;
          overflow  <= ovf;
          // A nonzero magnitude either overflowed or left digits behind.
          neg       <= sign & (ovf | (scratch != '0));
          lead_zero <= lead_zeros(result);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb_bin2bcd_seq -- bench for bin2bcd_seq in three configurations:
// inst 0: 12-bit unsigned, 4 digits; inst 1: 12-bit unsigned, 3 digits;
// inst 2: 12-bit signed, 4 digits. A transaction-level model predicts
// every output each cycle; directed sequences pin literal results.
module tb_bin2bcd_seq;

  typedef struct packed {
    logic [15:0] bcd;
    logic [3:0]  lz;
    logic        neg;
    logic        ovf;
  } res_t;

  logic        clk;
  logic        rst;
  logic [2:0]  st;
  logic [11:0] bin [3];

  logic [2:0]  busy_o, done_o, neg_o, ovf_o;
  logic [15:0] bcd_o [3];
  logic [3:0]  lz_o  [3];

  logic [15:0] bcd0, bcd2;
  logic [11:0] bcd1;
  logic [3:0]  lz0, lz2;
  logic [2:0]  lz1;

  int checks = 0;
  int errors = 0;

  bin2bcd_seq #(.BIN_W(12), .DIGITS(4), .SIGNED(0)) u0 (
    .clk(clk), .rst(rst), .start(st[0]), .bin_in(bin[0]),
    .busy(busy_o[0]), .done(done_o[0]), .bcd_out(bcd0),
    .neg(neg_o[0]), .overflow(ovf_o[0]), .lead_zero(lz0));

  bin2bcd_seq #(.BIN_W(12), .DIGITS(3), .SIGNED(0)) u1 (
    .clk(clk), .rst(rst), .start(st[1]), .bin_in(bin[1]),
    .busy(busy_o[1]), .done(done_o[1]), .bcd_out(bcd1),
    .neg(neg_o[1]), .overflow(ovf_o[1]), .lead_zero(lz1));

  bin2bcd_seq #(.BIN_W(12), .DIGITS(4), .SIGNED(1)) u2 (
    .clk(clk), .rst(rst), .start(st[2]), .bin_in(bin[2]),
    .busy(busy_o[2]), .done(done_o[2]), .bcd_out(bcd2),
    .neg(neg_o[2]), .overflow(ovf_o[2]), .lead_zero(lz2));

  assign bcd_o[0] = bcd0;
  assign bcd_o[1] = {4'h0, bcd1};
  assign bcd_o[2] = bcd2;
  assign lz_o[0]  = lz0;
  assign lz_o[1]  = {1'b0, lz1};
  assign lz_o[2]  = lz2;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int nd_of(input int i);
    return (i == 1) ? 3 : 4;
  endfunction

  function automatic bit sg_of(input int i);
    return (i == 2);
  endfunction

  // Reference conversion from plain integer arithmetic.
  function automatic res_t convert(input logic [11:0] v, input int nd, input bit sgn);
    res_t r;
    int   m;
    int   lim;
    bit   z;
    r = '0;
    m = int'(v);
    if (sgn && v[11]) m = 4096 - m;
    r.neg = sgn && v[11] && (m != 0);
    lim   = (10 ** nd) - 1;
    r.ovf = (m > lim);
    if (r.ovf) m = lim;
    for (int d = 0; d < nd; d++) begin
      r.bcd[4*d +: 4] = 4'(m % 10);
      m = m / 10;
    end
    z = 1'b1;
    for (int d = nd - 1; d >= 1; d--) begin
      z = z & (r.bcd[4*d +: 4] == 4'd0);
      r.lz[d] = z;
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40)
        $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: age = edges since accept, -1 when idle.
  int   age    [3];
  res_t hold   [3];
  res_t e_res  [3];
  logic e_done [3];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        age[i]    <= -1;
        hold[i]   <= '0;
        e_res[i]  <= '0;
        e_done[i] <= 1'b0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        e_done[i] <= 1'b0;
        if (age[i] < 0) begin
          if (st[i]) begin
            age[i]  <= 0;
            hold[i] <= convert(bin[i], nd_of(i), sg_of(i));
          end
        end else if (age[i] == 12) begin
          age[i]    <= -1;
          e_done[i] <= 1'b1;
          e_res[i]  <= hold[i];
        end else begin
          age[i] <= age[i] + 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("busy%0d", i), 32'(busy_o[i]), 32'(age[i] >= 0));
      chk($sformatf("done%0d", i), 32'(done_o[i]), 32'(e_done[i]));
      chk($sformatf("bcd%0d", i),  32'(bcd_o[i]),  32'(e_res[i].bcd));
      chk($sformatf("neg%0d", i),  32'(neg_o[i]),  32'(e_res[i].neg));
      chk($sformatf("ovf%0d", i),  32'(ovf_o[i]),  32'(e_res[i].ovf));
      chk($sformatf("lz%0d", i),   32'(lz_o[i]),   32'(e_res[i].lz));
    end
  end

  task automatic wait_done(input int i, output int k);
    k = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      k++;
      if (done_o[i]) return;
    end
    chk("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic run(input int i, input logic [11:0] v, output int k);
    @(negedge clk);
    st[i]  = 1'b1;
    bin[i] = v;
    @(negedge clk);
    st[i] = 1'b0;
    wait_done(i, k);
  endtask

  task automatic count_dones(input int i, input int cycles, output int n);
    n = 0;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      if (done_o[i]) n++;
    end
  endtask

  initial begin
    int k;
    int n;
    rst = 1'b1;
    st  = '0;
    for (int i = 0; i < 3; i++) bin[i] = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy_o[0]), 32'd0);
    chk("rst_done", 32'(done_o[0]), 32'd0);
    chk("rst_bcd",  32'(bcd_o[0]),  32'd0);
    chk("rst_lz",   32'(lz_o[0]),   32'd0);
    rst = 1'b0;

    // Full-scale 12-bit value
    run(0, 12'd4095, k);
    chk("lat_4095", 32'(k), 32'd13);
    chk("bcd_4095", 32'(bcd_o[0]), 32'h4095);
    chk("ovf_4095", 32'(ovf_o[0]), 32'd0);
    chk("lz_4095",  32'(lz_o[0]),  32'b0000);

    // Back-to-back: start held high through the first conversion
    @(negedge clk);
    st[0]  = 1'b1;
    bin[0] = 12'd7;
    @(negedge clk);
    bin[0] = 12'd0;
    wait_done(0, k);
    chk("lat_7", 32'(k), 32'd13);
    chk("bcd_7", 32'(bcd_o[0]), 32'h0007);
    chk("lz_7",  32'(lz_o[0]),  32'b1110);
    @(negedge clk);
    chk("accept_e14", 32'(busy_o[0]), 32'd1);
    st[0] = 1'b0;
    wait_done(0, k);
    chk("lat_0", 32'(k), 32'd13);
    chk("bcd_0", 32'(bcd_o[0]), 32'h0000);
    chk("lz_0",  32'(lz_o[0]),  32'b1110);

    // Three-digit overflow saturation
    run(1, 12'd1000, k);
    chk("bcd_1000", 32'(bcd_o[1]), 32'h0999);
    chk("ovf_1000", 32'(ovf_o[1]), 32'd1);
    run(1, 12'd999, k);
    chk("bcd_999", 32'(bcd_o[1]), 32'h0999);
    chk("ovf_999", 32'(ovf_o[1]), 32'd0);
    chk("lz_999",  32'(lz_o[1]),  32'b000);

    // Signed input
    run(2, 12'h800, k);
    chk("neg_m2048", 32'(neg_o[2]), 32'd1);
    chk("bcd_m2048", 32'(bcd_o[2]), 32'h2048);
    run(2, 12'hFFF, k);
    chk("neg_m1", 32'(neg_o[2]), 32'd1);
    chk("bcd_m1", 32'(bcd_o[2]), 32'h0001);
    chk("lz_m1",  32'(lz_o[2]),  32'b1110);
    run(2, 12'h000, k);
    chk("neg_s0", 32'(neg_o[2]), 32'd0);
    chk("bcd_s0", 32'(bcd_o[2]), 32'h0000);

    // Start and bin_in changes while busy are ignored
    @(negedge clk);
    st[0]  = 1'b1;
    bin[0] = 12'd1234;
    @(negedge clk);
    st[0] = 1'b0;
    repeat (4) @(negedge clk);
    st[0]  = 1'b1;
    bin[0] = 12'd999;
    @(negedge clk);
    st[0] = 1'b0;
    wait_done(0, k);
    chk("lat_1234", 32'(k), 32'd8);
    chk("bcd_1234", 32'(bcd_o[0]), 32'h1234);
    chk("lz_1234",  32'(lz_o[0]),  32'b0000);
    count_dones(0, 20, n);
    chk("no_second_done", 32'(n), 32'd0);

    // Asynchronous reset mid-conversion
    @(negedge clk);
    st[0]  = 1'b1;
    bin[0] = 12'd555;
    @(negedge clk);
    st[0] = 1'b0;
    repeat (5) @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("arst_busy", 32'(busy_o[0]), 32'd0);
    chk("arst_bcd",  32'(bcd_o[0]),  32'd0);
    chk("arst_done", 32'(done_o[0]), 32'd0);
    chk("arst_lz",   32'(lz_o[0]),   32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    count_dones(0, 20, n);
    chk("arst_no_done", 32'(n), 32'd0);
    run(0, 12'd321, k);
    chk("lat_321", 32'(k), 32'd13);
    chk("bcd_321", 32'(bcd_o[0]), 32'h0321);
    chk("lz_321",  32'(lz_o[0]),  32'b1000);

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
